// File: rtl/pipeline_scoreboard.sv
// Register-hazard interlock for the register-fetch stage: tracks outstanding
// writes per architectural register and gates issue on RAW hazards and counter overflow.
module pipeline_scoreboard #(
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic        issue_rs_used,
  input  logic [4:0]  issue_rt,
  input  logic        issue_rt_used,
  input  logic [4:0]  issue_rd,
  input  logic        issue_rd_we,
  output logic        issue_ready,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] stall_count
);

  logic [CNT_W-1:0] cnt     [NREGS];
  logic [CNT_W-1:0] cnt_nxt [NREGS];
  logic [CNT_W-1:0] cnt_rs, cnt_rt, cnt_rd;
  logic             hazard_rs, hazard_rt, overflow, fire, busy_nxt;

  always_comb begin
    cnt_rs = cnt[issue_rs];
    cnt_rt = cnt[issue_rt];
    cnt_rd = cnt[issue_rd];
  end

  // A retiring last write clears the hazard this cycle because the regfile writes through.
  always_comb begin
    hazard_rs   = issue_rs_used && (cnt_rs != '0) &&
                  !(wb_valid && (wb_rd == issue_rs) && (cnt_rs == CNT_W'(1)));
    hazard_rt   = issue_rt_used && (cnt_rt != '0) &&
                  !(wb_valid && (wb_rd == issue_rt) && (cnt_rt == CNT_W'(1)));
    overflow    = issue_rd_we && (issue_rd != 5'd0) && (cnt_rd == '1) &&
                  !(wb_valid && (wb_rd == issue_rd));
    issue_ready = !flush && !hazard_rs && !hazard_rt && !overflow;
    fire        = issue_valid && issue_ready;
  end

  always_comb begin
    busy_nxt = 1'b0;
    for (int unsigned r = 0; r < NREGS; r++) begin
      logic inc, dec;
      inc = fire && issue_rd_we && (issue_rd == 5'(r)) && (r != 0);
      dec = wb_valid && (wb_rd == 5'(r)) && (cnt[r] != '0);
      cnt_nxt[r] = cnt[r];
      if (flush)
        cnt_nxt[r] = '0;
      else if (inc && !dec)
        cnt_nxt[r] = cnt[r] + CNT_W'(1);
      else if (dec && !inc)
        cnt_nxt[r] = cnt[r] - CNT_W'(1);
      busy_nxt = busy_nxt | (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt[r] <= '0;
      busy        <= 1'b0;
      stall_count <= '0;
    end else begin
      for (int unsigned r = 0; r < NREGS; r++)
        cnt[r] <= cnt_nxt[r];
      busy <= busy_nxt;
      if (issue_valid && !issue_ready && (stall_count != '1))
        stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Self-checking bench for pipeline_scoreboard: directed hazard scenarios plus
// randomized traffic compared against a pending-write-count reference model.
module tb_pipeline_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rs = '0, issue_rt = '0, issue_rd = '0, wb_rd = '0;
  logic        issue_rs_used = 1'b0, issue_rt_used = 1'b0, issue_rd_we = 1'b0;
  logic        wb_valid = 1'b0, flush = 1'b0;
  logic        issue_ready, busy;
  logic [31:0] stall_count;

  pipeline_scoreboard #(.NREGS(32), .CNT_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rs_used(issue_rs_used),
    .issue_rt(issue_rt), .issue_rt_used(issue_rt_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy(busy), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model: number of writes issued but not yet retired per register.
  int          pend [32];
  longint      stall_m;
  localparam int MAXP = 3;
  logic        last_ready;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit model_ready(input bit rsu, input int rs, input bit rtu, input int rt,
                                     input bit we, input int rd, input bit wbv, input int wbrd,
                                     input bit fl);
    int left_rs, left_rt;
    left_rs = pend[rs] - ((wbv && wbrd == rs && pend[rs] > 0) ? 1 : 0);
    left_rt = pend[rt] - ((wbv && wbrd == rt && pend[rt] > 0) ? 1 : 0);
    if (fl) return 0;
    if (rsu && left_rs > 0) return 0;
    if (rtu && left_rt > 0) return 0;
    if (we && rd != 0 && pend[rd] >= MAXP && !(wbv && wbrd == rd)) return 0;
    return 1;
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < 32; i++) if (pend[i] != 0) return 1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend[i] = 0;
    stall_m = 0;
  endtask

  // One clock cycle: drive, check combinational ready, clock, update model, check state.
  task automatic cycle(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                       input int rd, input bit we, input bit wbv, input int wbrd, input bit fl);
    bit exp_ready;
    @(negedge clk);
    issue_valid = v; issue_rs = 5'(rs); issue_rs_used = rsu; issue_rt = 5'(rt);
    issue_rt_used = rtu; issue_rd = 5'(rd); issue_rd_we = we;
    wb_valid = wbv; wb_rd = 5'(wbrd); flush = fl;
    #1;
    exp_ready = model_ready(rsu, rs, rtu, rt, we, rd, wbv, wbrd, fl);
    last_ready = issue_ready;
    check("issue_ready", {31'd0, issue_ready}, {31'd0, exp_ready});
    @(posedge clk);
    if (fl) begin
      for (int i = 0; i < 32; i++) pend[i] = 0;
    end else begin
      if (wbv && pend[wbrd] > 0) pend[wbrd]--;
      if (v && exp_ready && we && rd != 0) pend[rd]++;
    end
    if (v && !exp_ready && stall_m < 64'hFFFF_FFFF) stall_m++;
    #1;
    check("busy", {31'd0, busy}, {31'd0, model_busy()});
    check("stall_count", stall_count, stall_m[31:0]);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_stall", stall_count, 32'd0);
    check("reset_ready", {31'd0, issue_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    // Back-to-back RAW on r5, released by a same-cycle writeback.
    cycle(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    check("raw_stall", {31'd0, last_ready}, 32'd0);
    cycle(1, 5, 1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5, 1, 0, 0, 0, 0, 1, 5, 0);
    check("raw_wb_release", {31'd0, last_ready}, 32'd1);
    check("raw_stalls", stall_count, 32'd2);

    // Register 0 never pending.
    cycle(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    check("r0_ready", {31'd0, last_ready}, 32'd1);

    // WAW depth and overflow on r7.
    repeat (3) cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    check("overflow_block", {31'd0, last_ready}, 32'd0);
    cycle(1, 0, 0, 0, 0, 7, 1, 1, 7, 0);
    check("overflow_wb_fire", {31'd0, last_ready}, 32'd1);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 1, 7, 0);
    check("waw_drained", {31'd0, busy}, 32'd0);

    // Simultaneous inc/dec on r9.
    cycle(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 9, 1, 1, 9, 0);
    cycle(1, 9, 1, 0, 0, 0, 0, 0, 0, 0);
    check("incdec_still_pending", {31'd0, last_ready}, 32'd0);
    cycle(1, 9, 1, 0, 0, 0, 0, 1, 9, 0);

    // Flush with pending r3, r12, then stray writeback.
    cycle(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 12, 1, 0, 0, 0);
    cycle(1, 3, 1, 12, 1, 0, 0, 0, 0, 1);
    check("flush_not_ready", {31'd0, last_ready}, 32'd0);
    cycle(1, 3, 1, 12, 1, 0, 0, 0, 0, 0);
    check("post_flush_ready", {31'd0, last_ready}, 32'd1);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);
    cycle(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    check("no_underflow", {31'd0, last_ready}, 32'd1);

    // Randomized traffic over a small register window to provoke hazards.
    for (int n = 0; n < 3000; n++) begin
      int rs, rt, rd, wbrd;
      rs   = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 4));
      rt   = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 4));
      rd   = (($urandom % 8) == 0) ? 0 : int'($urandom_range(1, 4));
      wbrd = int'($urandom_range(0, 4));
      cycle($urandom % 4 != 0, rs, $urandom % 2 == 1, rt, $urandom % 2 == 1,
            rd, $urandom % 4 != 0, $urandom % 2 == 1, wbrd, $urandom % 40 == 0);
    end

    // Asynchronous reset between edges with pending writes and stalls.
    model_reset();
    @(negedge clk); rst_n = 1'b0; #1; rst_n = 1'b1;
    cycle(1, 0, 0, 0, 0, 6, 1, 0, 0, 0);
    repeat (5) cycle(1, 6, 1, 0, 0, 0, 0, 0, 0, 0);
    check("pre_areset_stall", stall_count, 32'd5);
    @(negedge clk);
    issue_valid = 1'b1; issue_rs = 5'd6; issue_rs_used = 1'b1;
    issue_rd_we = 1'b0; wb_valid = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("areset_busy", {31'd0, busy}, 32'd0);
    check("areset_stall", stall_count, 32'd0);
    check("areset_ready", {31'd0, issue_ready}, 32'd1);
    #1 rst_n = 1'b1;
    model_reset();
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_scoreboard.md
Name: pipeline_scoreboard

Overview:
- Register-hazard interlock controller for the register-fetch stage.
- Per architectural register, counts outstanding writes issued but not yet written back.
- Gates issue so no instruction reads rs/rt while a write to that register is in flight.
- Sits beside the regfile read ports, with a writeback-side clear port and a flush port. Also exposes a stall-cycle performance counter.

Parameters:
- NREGS, 32, number of architectural registers (index width fixed at 5).
- CNT_W, 2, width of each per-register in-flight counter (max 2^CNT_W-1 outstanding writes per register).

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  decode presents an instruction for issue
- issue_rs  in  5  source register 0 index (inst[25:21])
- issue_rs_used  in  1  instruction reads rs
- issue_rt  in  5  source register 1 index (inst[20:16])
- issue_rt_used  in  1  instruction reads rt
- issue_rd  in  5  destination register index
- issue_rd_we  in  1  instruction writes issue_rd
- issue_ready  out  1  combinational; instruction may issue this cycle
- wb_valid  in  1  writeback retires one write this cycle
- wb_rd  in  5  register being written back
- flush  in  1  synchronous; kill all in-flight writes
- busy  out  1  registered; any counter nonzero
- stall_count  out  32  registered; saturating count of stalled cycles

Behaviour:
- Reset (rst_n=0, asynchronous): all counters 0, busy=0, stall_count=0. issue_ready then follows its combinational equation, which is 1 with all counters 0.
- Register 0: its counter is never incremented and always reads 0. rs/rt/rd of 0 never cause hazards.
- hazard_rs = issue_rs_used & cnt[issue_rs]!=0 & !(wb_valid & wb_rd==issue_rs & cnt[issue_rs]==1). The regfile writes through in the same cycle, so the last pending write retiring this cycle clears the hazard.
- hazard_rt: same equation using rt.
- overflow = issue_rd_we & issue_rd!=0 & cnt[issue_rd]==max & !(wb_valid & wb_rd==issue_rd).
- issue_ready = !flush & !hazard_rs & !hazard_rt & !overflow. It is independent of issue_valid; there is no combinational path from issue_valid.
- fire = issue_valid & issue_ready.
- Counter update per register r, each cycle:
  - inc = fire & issue_rd_we & issue_rd==r & r!=0
  - dec = wb_valid & wb_rd==r & cnt[r]!=0
  - inc&dec: unchanged. inc only: +1. dec only: -1.
- wb_valid on a register with cnt==0 is ignored: no underflow, counter stays 0.
- flush=1: next state of all counters is 0, overriding inc/dec in the same cycle. issue_ready=0 during the flush cycle.
- busy <= OR of next-state counters. It reflects the state after the edge.
- stall_count increments when issue_valid & !issue_ready and saturates at 0xFFFFFFFF. flush cycles with issue_valid=1 count as stalls. stall_count is cleared only by reset.
- Latency: a fire at edge N makes the register pending for instructions evaluated after edge N. A wb at cycle N unblocks readers combinationally in cycle N.
- Reset asserted mid-operation: all pending state is lost immediately. Upstream must drain or flush consistently.

Test Plan:
- Back-to-back RAW: issue rd=5 (we=1), next cycle rs=5 used -> issue_ready=0, stall_count increments each cycle. Assert wb_valid, wb_rd=5 -> issue_ready=1 in that same cycle and the instruction fires; busy=0 after the edge.
- Register 0: issue rd=0 we=1, then rs=0,rt=0 used -> issue_ready=1 every cycle, busy stays 0, stall_count stays 0.
- WAW depth: issue rd=7 three times (cnt=3), fourth issue rd=7 -> issue_ready=0 (overflow). Same fourth issue with wb_valid wb_rd=7 that cycle -> fires, cnt stays 3. Three further wb -> busy=0.
- Simultaneous inc/dec: cnt[9]=1; fire rd=9 plus wb rd=9 in the same cycle -> cnt[9]=1, and a following reader of rs=9 stalls until the next wb.
- Flush: pending rd=3 and rd=12, assert flush with issue_valid=1 -> issue_ready=0, stall_count+1. Next cycle busy=0 and rs=3/rt=12 readers issue immediately. A stray wb rd=3 afterwards -> no underflow, cnt stays 0.
- Async reset: with counters nonzero and stall_count=5, pulse rst_n low between clock edges -> busy=0, stall_count=0, issue_ready=1 before the next rising edge.
